// File: rtl/fir_pkg.sv
// Constants and types shared by the FIR sample window and the FIR core.
// The tap-mask helper selects the delay-line slots that are live for a given tap count.
package fir_pkg;

   localparam int DATA_W   = 16;
   localparam int MAX_TAPS = 15;
   localparam int TAP_W    = 4;
   localparam int WINDOW_W = DATA_W * MAX_TAPS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } win_state_e;

   function automatic logic [WINDOW_W-1:0] tap_mask(input logic [TAP_W-1:0] tap);
      logic [WINDOW_W-1:0] mask;
      mask = '0;
      for (int k = 0; k < MAX_TAPS; k++) begin
         if (k < int'(tap)) begin
            mask[k*DATA_W +: DATA_W] = '1;
         end else begin
            mask[k*DATA_W +: DATA_W] = '0;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/fir_sample_window.sv
// Delay line feeding the FIR core: accepts samples over valid/ready and presents
// the newest window_tap samples (slot 0 = newest) with a strobe once the window is full.
module fir_sample_window
   import fir_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_tap_we,
   input  logic [TAP_W-1:0]    cfg_tap,
   input  logic                flush,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATA_W-1:0]   s_data,
   output logic [WINDOW_W-1:0] window_data,
   output logic [TAP_W-1:0]    window_tap,
   output logic                window_valid,
   output logic [TAP_W-1:0]    fill_level
);

   win_state_e          state_r;
   logic [WINDOW_W-1:0] window_r;
   logic [TAP_W-1:0]    tap_r;
   logic [TAP_W-1:0]    fill_r;
   logic                valid_r;

   logic                accept_s;
   logic [TAP_W-1:0]    fill_next_s;
   logic                full_next_s;
   logic [WINDOW_W-1:0] shifted_s;

   // Ready is withheld whenever a config write or flush owns the cycle.
   always_comb begin
      s_ready     = (state_r != IDLE) & ~cfg_tap_we & ~flush;
      accept_s    = s_valid & s_ready;
      if (fill_r == tap_r) begin
         fill_next_s = tap_r;
      end else begin
         fill_next_s = fill_r + 4'd1;
      end
      full_next_s = (fill_next_s == tap_r);
      // Slots at or beyond the tap count are forced to zero so the core sees a clean window.
      shifted_s   = {window_r[WINDOW_W-DATA_W-1:0], s_data} & tap_mask(tap_r);
   end

   // Window FSM, delay line and fill counter with config > flush > accept priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         window_r <= '0;
         tap_r    <= 4'd0;
         fill_r   <= 4'd0;
         valid_r  <= 1'b0;
      end else if (cfg_tap_we) begin
         tap_r    <= cfg_tap;
         window_r <= '0;
         fill_r   <= 4'd0;
         valid_r  <= 1'b0;
         state_r  <= (cfg_tap == 4'd0) ? IDLE : FILL;
      end else if (flush) begin
         window_r <= '0;
         fill_r   <= 4'd0;
         valid_r  <= 1'b0;
         state_r  <= (tap_r == 4'd0) ? IDLE : FILL;
      end else if (accept_s) begin
         window_r <= shifted_s;
         fill_r   <= fill_next_s;
         valid_r  <= full_next_s;
         state_r  <= full_next_s ? RUN : FILL;
      end else begin
         valid_r  <= 1'b0;
         case (state_r)
            IDLE:    state_r <= IDLE;
            FILL:    state_r <= FILL;
            RUN:     state_r <= RUN;
            default: state_r <= IDLE;
         endcase
      end
   end

   assign window_data  = window_r;
   assign window_tap   = tap_r;
   assign fill_level   = fill_r;
   assign window_valid = valid_r;

endmodule

// File: tb/tb_fir_sample_window.sv
// Directed bench for fir_sample_window: a reference window model feeds a scoreboard
// that is drained whenever the DUT strobes window_valid.
module tb_fir_sample_window;
   import fir_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                cfg_tap_we;
   logic [TAP_W-1:0]    cfg_tap;
   logic                flush;
   logic                s_valid;
   logic                s_ready;
   logic [DATA_W-1:0]   s_data;
   logic [WINDOW_W-1:0] window_data;
   logic [TAP_W-1:0]    window_tap;
   logic                window_valid;
   logic [TAP_W-1:0]    fill_level;

   int total = 0;
   int bad   = 0;

   logic [WINDOW_W-1:0] exp_q[$];
   logic [WINDOW_W-1:0] m_win;
   logic [TAP_W-1:0]    m_tap;
   logic [TAP_W-1:0]    m_fill;

   fir_sample_window dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cfg_tap_we   (cfg_tap_we),
      .cfg_tap      (cfg_tap),
      .flush        (flush),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .window_data  (window_data),
      .window_tap   (window_tap),
      .window_valid (window_valid),
      .fill_level   (fill_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WINDOW_W-1:0] obs, input logic [WINDOW_W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [DATA_W-1:0] d);
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      #1;
      chk("s_ready_push", WINDOW_W'(s_ready), WINDOW_W'(1'b1));
      m_win = {m_win[WINDOW_W-DATA_W-1:0], d};
      for (int k = 0; k < MAX_TAPS; k++) begin
         if (k >= int'(m_tap)) m_win[k*DATA_W +: DATA_W] = '0;
      end
      if (m_fill != m_tap) m_fill = m_fill + 4'd1;
      if (m_fill == m_tap) exp_q.push_back(m_win);
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      chk("window_valid", WINDOW_W'(window_valid), WINDOW_W'(m_fill == m_tap));
      if (window_valid === 1'b1) begin
         if (exp_q.size() != 0) begin
            chk("sb_window", window_data, exp_q.pop_front());
         end else begin
            total++;
            bad++;
            $error("FAIL sb_underflow observed=pulse expected=no_pulse");
         end
      end
      chk("window_data", window_data, m_win);
      chk("fill_level", WINDOW_W'(fill_level), WINDOW_W'(m_fill));
   endtask

   task automatic cfg(input logic [TAP_W-1:0] t, input logic sv);
      @(negedge clk);
      cfg_tap_we = 1'b1;
      cfg_tap    = t;
      s_valid    = sv;
      s_data     = 16'hBEEF;
      #1;
      chk("s_ready_cfg", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
      @(posedge clk);
      #1;
      cfg_tap_we = 1'b0;
      s_valid    = 1'b0;
      m_tap  = t;
      m_win  = '0;
      m_fill = 4'd0;
      chk("cfg_window", window_data, m_win);
      chk("cfg_tap", WINDOW_W'(window_tap), WINDOW_W'(m_tap));
      chk("cfg_fill", WINDOW_W'(fill_level), WINDOW_W'(m_fill));
      chk("cfg_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
   endtask

   task automatic do_flush(input logic sv);
      @(negedge clk);
      flush   = 1'b1;
      s_valid = sv;
      s_data  = 16'h5A5A;
      #1;
      chk("s_ready_flush", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
      @(posedge clk);
      #1;
      flush   = 1'b0;
      s_valid = 1'b0;
      m_win  = '0;
      m_fill = 4'd0;
      chk("flush_window", window_data, m_win);
      chk("flush_fill", WINDOW_W'(fill_level), WINDOW_W'(m_fill));
      chk("flush_tap", WINDOW_W'(window_tap), WINDOW_W'(m_tap));
      chk("flush_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk("gap_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
         chk("gap_hold", window_data, m_win);
      end
   endtask

   initial begin
      logic [WINDOW_W-1:0] w;
      rst_n      = 1'b0;
      cfg_tap_we = 1'b0;
      cfg_tap    = 4'd0;
      flush      = 1'b0;
      s_valid    = 1'b0;
      s_data     = 16'h0000;
      m_win      = '0;
      m_tap      = 4'd0;
      m_fill     = 4'd0;
      #2;
      chk("rst_window", window_data, '0);
      chk("rst_tap", WINDOW_W'(window_tap), WINDOW_W'(4'd0));
      chk("rst_fill", WINDOW_W'(fill_level), WINDOW_W'(4'd0));
      chk("rst_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
      chk("rst_ready", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
      #20;
      rst_n = 1'b1;

      // tap = 3: pulse only once the third sample lands
      cfg(4'd3, 1'b0);
      push(16'h0001);
      push(16'h0002);
      push(16'h0003);
      w = '0;
      w[47:0] = 48'h0001_0002_0003;
      chk("tap3_window", window_data, w);
      push(16'h0004);
      w[47:0] = 48'h0002_0003_0004;
      chk("tap3_window_run", window_data, w);
      gap(2);

      // tap = 15: sixteenth sample drops the oldest
      cfg(4'd15, 1'b0);
      for (int i = 0; i < 16; i++) push(16'h0010 + 16'(i));
      chk("tap15_slot0", WINDOW_W'(window_data[15:0]), WINDOW_W'(16'h001F));
      chk("tap15_slot14", WINDOW_W'(window_data[239:224]), WINDOW_W'(16'h0011));
      chk("tap15_fill", WINDOW_W'(fill_level), WINDOW_W'(4'd15));

      // tap = 0: never ready, never valid
      cfg(4'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data  = 16'h1234;
         #1;
         chk("tap0_ready", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
         @(posedge clk);
         #1;
         chk("tap0_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
         chk("tap0_window", window_data, '0);
      end
      s_valid = 1'b0;

      // reconfigure out of RUN while a sample is offered
      cfg(4'd5, 1'b0);
      for (int i = 0; i < 6; i++) push(16'h0100 + 16'(i));
      cfg(4'd2, 1'b1);
      push(16'hFFFC);
      push(16'h0200);
      w = '0;
      w[31:0] = 32'hFFFC_0200;
      chk("tap2_signed", window_data, w);

      // flush mid-FILL with a competing sample
      cfg(4'd4, 1'b0);
      push(16'h0A01);
      push(16'h0A02);
      do_flush(1'b1);
      push(16'h0B01);
      push(16'h0B02);

      // asynchronous reset between edges
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_window", window_data, '0);
      chk("arst_tap", WINDOW_W'(window_tap), WINDOW_W'(4'd0));
      chk("arst_fill", WINDOW_W'(fill_level), WINDOW_W'(4'd0));
      chk("arst_valid", WINDOW_W'(window_valid), WINDOW_W'(1'b0));
      chk("arst_ready", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
      #4;
      rst_n = 1'b1;
      m_win  = '0;
      m_tap  = 4'd0;
      m_fill = 4'd0;
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         #1;
         chk("post_rst_ready", WINDOW_W'(s_ready), WINDOW_W'(1'b0));
      end
      s_valid = 1'b0;

      // tap = 1: first accept goes straight to RUN
      cfg(4'd1, 1'b0);
      push(16'h8007);
      push(16'h7FFF);
      gap(1);

      chk("sb_leftover", WINDOW_W'(exp_q.size()), WINDOW_W'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
